ikaopll_slotgen: RTL and testbench

Parametrised slot/timing generator, successor to the fixed 18-slot OPLL timing generator. Divides the master-clock enable into phi1 positive/negative clock enables. Sequences a frame of NUM_CH×OPS_PER_CH operator slots and publishes slot, channel and operator indices, delayed slot taps and frame strobes. Rhythm-mode selection is latched only at frame boundaries. Sits between the chip clock/reset input and the operator, envelope and accumulator pipelines.

---
 rtl/ikaopll_slotgen.sv | 117 +++++++++++
 tb/tb_ikaopll_slotgen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_slotgen.sv
// Slot/timing generator: splits phiM enables into phi1 edge enables and walks the
// {channel, operator} slot frame, publishing indices, a delayed slot tap and frame strobes.
module ikaopll_slotgen #(
    parameter int PHI_DIV    = 4,
    parameter int NUM_CH     = 9,
    parameter int OPS_PER_CH = 2,
    parameter int RHY_CH     = 3,
    parameter int DLY        = 2,
    localparam int SLOTS = NUM_CH * OPS_PER_CH,
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OW    = (OPS_PER_CH > 1) ? $clog2(OPS_PER_CH) : 1
) (
    input  logic          i_EMUCLK,
    input  logic          i_RST,
    input  logic          i_phiM_PCEN_n,
    input  logic          i_RHYTHM_EN,
    output logic          o_phi1_PCEN_n,
    output logic          o_phi1_NCEN_n,
    output logic [SW-1:0] o_SLOT,
    output logic [CW-1:0] o_CH,
    output logic [OW-1:0] o_OP,
    output logic [SW-1:0] o_SLOT_DLY,
    output logic          o_FRAME_START,
    output logic          o_SAMPLE_EN,
    output logic          o_RHYTHM_ACT,
    output logic          o_RHY_SLOT
);

    localparam int PW = (PHI_DIV > 1) ? $clog2(PHI_DIV) : 1;

    logic [PW-1:0] ph;
    logic [CW-1:0] ch;
    logic [OW-1:0] op;
    logic [SW-1:0] slot;
    logic [SW-1:0] slot_p [DLY];
    logic          rhythm_act;

    logic phim_en;
    logic pcen;
    logic ncen;
    logic op_last;
    logic ch_last;
    logic wrap;
    logic in_rhy_ch;

    // Reset masks the enables so nothing downstream sees an edge while held.
    assign phim_en = ~i_phiM_PCEN_n & ~i_RST;
    assign pcen    = phim_en & (ph == PW'(0));
    assign ncen    = phim_en & (ph == PW'(PHI_DIV / 2));
    assign op_last = (op == OW'(OPS_PER_CH - 1));
    assign ch_last = (ch == CW'(NUM_CH - 1));
    assign wrap    = ncen & (slot == SW'(SLOTS - 1));

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            ph <= '0;
        end else if (~i_phiM_PCEN_n) begin
            ph <= (ph == PW'(PHI_DIV - 1)) ? '0 : ph + PW'(1);
        end
    end

    // Slot counter: linear slot index is kept in its own register to avoid a multiplier.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            ch   <= '0;
            op   <= '0;
            slot <= '0;
        end else if (ncen) begin
            if (op_last) begin
                op <= '0;
                ch <= ch_last ? '0 : ch + CW'(1);
            end else begin
                op <= op + OW'(1);
            end
            slot <= (op_last & ch_last) ? '0 : slot + SW'(1);
        end
    end

    // Delayed slot taps, one stage per phi1 cycle.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            for (int i = 0; i < DLY; i++) slot_p[i] <= '0;
        end else if (ncen) begin
            slot_p[0] <= slot;
            for (int i = 1; i < DLY; i++) slot_p[i] <= slot_p[i-1];
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            rhythm_act <= 1'b0;
        end else if (wrap) begin
            rhythm_act <= i_RHYTHM_EN;
        end
    end

    generate
        if (RHY_CH == 0) begin : g_no_rhy
            assign in_rhy_ch = 1'b0;
        end else begin : g_rhy
            assign in_rhy_ch = (32'(ch) >= 32'(NUM_CH - RHY_CH));
        end
    endgenerate

    assign o_phi1_PCEN_n = ~pcen;
    assign o_phi1_NCEN_n = ~ncen;
    assign o_SLOT        = slot;
    assign o_CH          = ch;
    assign o_OP          = op;
    assign o_SLOT_DLY    = slot_p[DLY-1];
    assign o_FRAME_START = i_RST | (slot == '0);
    assign o_SAMPLE_EN   = wrap;
    assign o_RHYTHM_ACT  = rhythm_act;
    assign o_RHY_SLOT    = ~i_RST & rhythm_act & in_rhy_ch;

endmodule

// File: tb/tb_ikaopll_slotgen.sv
// Scoreboard bench for ikaopll_slotgen: default instance plus a 6x4, PHI_DIV=2 instance.
module tb_ikaopll_slotgen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a  = 1'b1;
    logic sel    = 1'b0;
    logic phim_n = 1'b0;
    logic rhy    = 1'b0;
    logic rst1, rst2;
    assign rst1 = rst_a | sel;
    assign rst2 = rst_a | ~sel;

    logic       a_pcen_n, a_ncen_n, a_fstart, a_sample, a_ract, a_rslot;
    logic [4:0] a_slot, a_sdly;
    logic [3:0] a_ch;
    logic [0:0] a_op;

    logic       b_pcen_n, b_ncen_n, b_fstart, b_sample, b_ract, b_rslot;
    logic [4:0] b_slot, b_sdly;
    logic [2:0] b_ch;
    logic [1:0] b_op;

    ikaopll_slotgen dut_a (
        .i_EMUCLK(clk), .i_RST(rst1), .i_phiM_PCEN_n(phim_n), .i_RHYTHM_EN(rhy),
        .o_phi1_PCEN_n(a_pcen_n), .o_phi1_NCEN_n(a_ncen_n), .o_SLOT(a_slot), .o_CH(a_ch),
        .o_OP(a_op), .o_SLOT_DLY(a_sdly), .o_FRAME_START(a_fstart), .o_SAMPLE_EN(a_sample),
        .o_RHYTHM_ACT(a_ract), .o_RHY_SLOT(a_rslot)
    );

    ikaopll_slotgen #(.PHI_DIV(2), .NUM_CH(6), .OPS_PER_CH(4), .RHY_CH(0), .DLY(2)) dut_b (
        .i_EMUCLK(clk), .i_RST(rst2), .i_phiM_PCEN_n(phim_n), .i_RHYTHM_EN(rhy),
        .o_phi1_PCEN_n(b_pcen_n), .o_phi1_NCEN_n(b_ncen_n), .o_SLOT(b_slot), .o_CH(b_ch),
        .o_OP(b_op), .o_SLOT_DLY(b_sdly), .o_FRAME_START(b_fstart), .o_SAMPLE_EN(b_sample),
        .o_RHYTHM_ACT(b_ract), .o_RHY_SLOT(b_rslot)
    );

    logic       m_rst, m_pcen_n, m_ncen_n, m_fstart, m_sample, m_ract, m_rslot;
    logic [7:0] m_slot, m_sdly, m_ch, m_op;
    assign m_rst    = sel ? rst2 : rst1;
    assign m_pcen_n = sel ? b_pcen_n : a_pcen_n;
    assign m_ncen_n = sel ? b_ncen_n : a_ncen_n;
    assign m_fstart = sel ? b_fstart : a_fstart;
    assign m_sample = sel ? b_sample : a_sample;
    assign m_ract   = sel ? b_ract : a_ract;
    assign m_rslot  = sel ? b_rslot : a_rslot;
    assign m_slot   = sel ? 8'(b_slot) : 8'(a_slot);
    assign m_sdly   = sel ? 8'(b_sdly) : 8'(a_sdly);
    assign m_ch     = sel ? 8'(b_ch) : 8'(a_ch);
    assign m_op     = sel ? 8'(b_op) : 8'(a_op);

    typedef struct packed {
        logic       kind;
        logic [15:0] cyc;
        logic [7:0] slot;
        logic [7:0] ch;
        logic [7:0] op;
        logic [7:0] sdly;
        logic       ract;
        logic       rslot;
        logic       sample;
        logic       fstart;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  drain_req = 0;
    int  drain_ack = 0;
    int  rel = 0;
    int  ev_n = 0;
    ev_t act, want;

    // Monitor: every enable/strobe cycle is one event, matched in order against the queue.
    always @(negedge clk) begin
        if (m_rst) begin
            rel = 0;
            checks++;
            if (!(m_pcen_n && m_ncen_n && !m_sample && m_fstart && !m_rslot)) begin
                errors++;
                $display("FAIL reset_outputs: got pcen_n=%b ncen_n=%b sample=%b frame_start=%b rhy_slot=%b, want 1 1 0 1 0",
                         m_pcen_n, m_ncen_n, m_sample, m_fstart, m_rslot);
            end
        end else begin
            checks++;
            if (!m_pcen_n && !m_ncen_n) begin
                errors++;
                $display("FAIL enable_overlap: got pcen_n=0 ncen_n=0 at cycle %0d, want at most one low", rel);
            end
            if (!m_pcen_n || !m_ncen_n || m_sample) begin
                act = '{kind: ~m_ncen_n, cyc: 16'(rel), slot: m_slot, ch: m_ch, op: m_op, sdly: m_sdly,
                        ract: m_ract, rslot: m_rslot, sample: m_sample, fstart: m_fstart};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0d cyc=%0d slot=%0d, want no event", act.kind, act.cyc, act.slot);
                end else begin
                    want = q.pop_front();
                    if (act !== want) begin
                        errors++;
                        $display("FAIL event_%0d: got kind=%0d cyc=%0d slot=%0d ch=%0d op=%0d sdly=%0d ract=%0d rslot=%0d sample=%0d fstart=%0d; want kind=%0d cyc=%0d slot=%0d ch=%0d op=%0d sdly=%0d ract=%0d rslot=%0d sample=%0d fstart=%0d",
                                 ev_n, act.kind, act.cyc, act.slot, act.ch, act.op, act.sdly, act.ract, act.rslot, act.sample, act.fstart,
                                 want.kind, want.cyc, want.slot, want.ch, want.op, want.sdly, want.ract, want.rslot, want.sample, want.fstart);
                    end
                end
                ev_n++;
            end
            rel++;
        end
        if (drain_ack != drain_req) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL queue_drain: got %0d expected events never seen, want 0", q.size());
            end
            q.delete();
            drain_ack = drain_req;
        end
    end

    // Expected events for a run from reset release: PCEN/NCEN alternate, one pair per slot.
    task automatic push_run(input int n_ev, input int phi, input int stride, input int nch,
                            input int ops, input int rhy_ch, input logic [2:0] ract_by_frame);
        int slots;
        int k;
        int s;
        ev_t x;
        slots = nch * ops;
        for (int e = 0; e < n_ev; e++) begin
            k = e / 2;
            s = k % slots;
            x.kind   = 1'(e % 2);
            x.cyc    = 16'(stride * (phi * k + (e % 2) * (phi / 2)));
            x.slot   = 8'(s);
            x.ch     = 8'(s / ops);
            x.op     = 8'(s % ops);
            x.sdly   = (k >= 2) ? 8'((k - 2) % slots) : 8'd0;
            x.ract   = ract_by_frame[k / slots];
            x.rslot  = x.ract && (rhy_ch > 0) && ((s / ops) >= (nch - rhy_ch));
            x.sample = (e % 2 == 1) && (s == slots - 1);
            x.fstart = (s == 0);
            q.push_back(x);
        end
    endtask

    task automatic do_reset(input int n);
        rst_a = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int ncyc, input int stride, input int rhy_on, input int rhy_off, input int rhy_on2);
        rst_a = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            phim_n = ((t % stride) != 0);
            if (t == rhy_on || t == rhy_on2) rhy = 1'b1;
            if (t == rhy_off) rhy = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        drain_req++;
        for (int i = 0; i < 10 && drain_ack != drain_req; i++) @(posedge clk);
        if (drain_ack != drain_req) begin
            $display("FAIL drain_handshake: got ack=%0d, want %0d", drain_ack, drain_req);
            $fatal(1, "monitor stalled");
        end
        #1;
    endtask

    initial begin
        do_reset(3);

        // Defaults, phiM every clock: two frames.
        push_run(72, 4, 1, 9, 2, 3, 3'b000);
        run(144, 1, -1, -1, -1);
        phim_n = 1'b1;
        drain();

        // Defaults, phiM every third clock: one frame.
        phim_n = 1'b0;
        do_reset(3);
        push_run(36, 4, 3, 9, 2, 3, 3'b000);
        run(216, 3, -1, -1, -1);
        phim_n = 1'b1;
        drain();

        // Rhythm request mid-frame, dropped and re-raised, then reset on slot 9's NCEN.
        phim_n = 1'b0;
        rhy = 1'b0;
        do_reset(3);
        push_run(91, 4, 1, 9, 2, 3, 3'b110);
        run(182, 1, 20, 84, 120);
        do_reset(2);
        drain();

        // After the aborted frame: back at slot 0, rhythm cleared and not relatched mid-frame.
        push_run(8, 4, 1, 9, 2, 3, 3'b000);
        rhy = 1'b1;
        run(16, 1, -1, -1, -1);
        phim_n = 1'b1;
        drain();

        // 6 channels x 4 operators, PHI_DIV=2, no rhythm channels.
        rhy = 1'b0;
        phim_n = 1'b0;
        rst_a = 1'b1;
        sel = 1'b1;
        do_reset(3);
        push_run(96, 2, 1, 6, 4, 0, 3'b010);
        rhy = 1'b1;
        run(96, 1, -1, -1, -1);
        phim_n = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
